sfu_norm: RTL

- Special-function unit directly downstream of the array controller; driven by its `sfu_acc` and `sfu_div` bits.
- Accumulate phase: captures psum rows popped from the output FIFO into a local row buffer, computing each row's L1 norm (sum of |x|).
- Divide phase: emits one normalized row per cycle, addressed for a write into pmem.
- Sits between the OFIFO read port and the pmem write-data port.

---
 rtl/sfu_norm.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/sfu_norm.sv
// sfu_norm -- row L1-normalisation unit between the OFIFO read port and the pmem write port.
//
// Accumulate phase: psum rows popped from the OFIFO are captured into a local row buffer.
// Each row's L1 norm S = sum |x_i| is computed as the row is written, and is stored with it.
// Divide phase: one buffered row per cycle is emitted as q_i = (x_i * 2^frac_bw) / S.
// The division is signed and truncates toward zero. Each emitted row is tagged with its buffer index.
//
// Ports
//   clk       in   rising-edge clock
//   reset     in   synchronous active-high reset, overrides everything
//   acc       in   accumulate enable (controller sfu_acc)
//   div       in   divide/emit enable (controller sfu_div)
//   in_valid  in   OFIFO row valid this cycle
//   in_data   in   col signed psum lanes, lane i at [(i+1)*psum_bw-1 : i*psum_bw]
//   out_valid out  out_data/out_row valid (registered, 1 cycle after an issuing div)
//   out_data  out  normalised row, same lane packing, holds when out_valid=0
//   out_row   out  buffer index of the emitted row (pmem address), holds when out_valid=0
//   busy      out  state is ACC or DIV
//   done      out  state is DONE
//   overflow  out  sticky: a row arrived while the buffer was full
module sfu_norm #(
   parameter int col         = 8,
   parameter int psum_bw     = 16,
   parameter int total_cycle = 8,
   parameter int addr_bw     = 4,
   parameter int frac_bw     = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       acc,
   input  logic                       div,
   input  logic                       in_valid,
   input  logic [col*psum_bw-1:0]     in_data,
   output logic                       out_valid,
   output logic [col*psum_bw-1:0]     out_data,
   output logic [addr_bw-1:0]         out_row,
   output logic                       busy,
   output logic                       done,
   output logic                       overflow
);

   localparam int sum_bw = psum_bw + $clog2(col);
   // One extra bit so the pointer can hold total_cycle itself ("buffer full").
   localparam int ptr_bw = addr_bw + 1;
   localparam int idx_bw = (total_cycle > 1) ? $clog2(total_cycle) : 1;
   localparam int num_bw = psum_bw + frac_bw;
   // Divider width covers both the scaled numerator and the zero-extended positive sum.
   localparam int div_bw = (num_bw > sum_bw + 1) ? num_bw + 1 : sum_bw + 2;
   localparam logic [ptr_bw-1:0] depth_c = ptr_bw'(total_cycle);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_ACC  = 2'd1;
   localparam logic [1:0] ST_DIV  = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   // |x| widened to the sum width, so that -2^(psum_bw-1) maps exactly to 2^(psum_bw-1).
   function automatic logic [sum_bw-1:0] lane_abs(input logic [psum_bw-1:0] x);
      logic [sum_bw-1:0] ext;
      ext = {{(sum_bw-psum_bw){x[psum_bw-1]}}, x};
      if (x[psum_bw-1]) return ~ext + sum_bw'(1);
      else              return ext;
   endfunction

   // Signed (x << frac_bw) / s with truncation toward zero. A zero norm gives 0.
   function automatic logic [psum_bw-1:0] lane_div(input logic [psum_bw-1:0] x,
                                                   input logic [sum_bw-1:0]  s);
      logic signed [div_bw-1:0] num;
      logic signed [div_bw-1:0] den;
      logic signed [div_bw-1:0] q;
      num = div_bw'($signed({x, {frac_bw{1'b0}}}));
      den = div_bw'($signed({1'b0, s}));
      q   = num / den;
      if (s == {sum_bw{1'b0}}) return {psum_bw{1'b0}};
      else                     return psum_bw'(q);
   endfunction

   logic [1:0]               state_r;
   logic [1:0]               state_nxt_s;
   logic [ptr_bw-1:0]        wr_ptr_r;
   logic [ptr_bw-1:0]        rd_ptr_r;
   logic [ptr_bw-1:0]        write_idx_s;
   logic                     wr_en_s;
   logic                     full_s;
   logic                     issue_s;
   logic                     restart_s;
   logic [sum_bw-1:0]        row_sum_s;
   logic [col*psum_bw-1:0]   rd_row_s;
   logic [sum_bw-1:0]        rd_sum_s;
   logic [col*psum_bw-1:0]   quot_s;
   logic [col*psum_bw-1:0]   row_buf_r [total_cycle];
   logic [sum_bw-1:0]        sum_buf_r [total_cycle];
   logic                     out_valid_r;
   logic [col*psum_bw-1:0]   out_data_r;
   logic [addr_bw-1:0]       out_row_r;
   logic                     busy_r;
   logic                     done_r;
   logic                     overflow_r;

   // A restart from DONE rewrites the buffer from row 0 in the same cycle.
   assign write_idx_s = restart_s ? {ptr_bw{1'b0}} : wr_ptr_r;
   assign full_s      = (write_idx_s >= depth_c);
   assign rd_row_s    = row_buf_r[rd_ptr_r[idx_bw-1:0]];
   assign rd_sum_s    = sum_buf_r[rd_ptr_r[idx_bw-1:0]];

   // Next-state and per-cycle action decode.
   always_comb begin
      state_nxt_s = state_r;
      wr_en_s     = 1'b0;
      issue_s     = 1'b0;
      restart_s   = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (acc) state_nxt_s = ST_ACC;
            else     state_nxt_s = ST_IDLE;
            wr_en_s = acc & in_valid & ~div;
         end
         ST_ACC: begin
            // div wins: no write on the cycle the phase changes.
            if (div) begin
               state_nxt_s = ST_DIV;
            end else begin
               state_nxt_s = ST_ACC;
               wr_en_s     = acc & in_valid;
            end
         end
         ST_DIV: begin
            if (wr_ptr_r == {ptr_bw{1'b0}}) begin
               state_nxt_s = ST_DONE;
            end else if (div && (rd_ptr_r < wr_ptr_r)) begin
               issue_s = 1'b1;
               if (rd_ptr_r + ptr_bw'(1) == wr_ptr_r) state_nxt_s = ST_DONE;
               else                                   state_nxt_s = ST_DIV;
            end else begin
               state_nxt_s = ST_DIV;
            end
         end
         ST_DONE: begin
            if (acc) begin
               state_nxt_s = ST_ACC;
               restart_s   = 1'b1;
               wr_en_s     = in_valid & ~div;
            end else begin
               state_nxt_s = ST_DONE;
            end
         end
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // L1 norm of the incoming row.
   always_comb begin
      row_sum_s = {sum_bw{1'b0}};
      for (int i = 0; i < col; i++) begin
         row_sum_s = row_sum_s + lane_abs(in_data[i*psum_bw +: psum_bw]);
      end
   end

   // Per-lane normalisation of the row at rd_ptr.
   always_comb begin
      quot_s = {(col*psum_bw){1'b0}};
      for (int i = 0; i < col; i++) begin
         quot_s[i*psum_bw +: psum_bw] = lane_div(rd_row_s[i*psum_bw +: psum_bw], rd_sum_s);
      end
   end

   // Row and norm storage. This is data only, so it needs no reset.
   always_ff @(posedge clk) begin
      if (wr_en_s && !full_s) begin
         row_buf_r[write_idx_s[idx_bw-1:0]] <= in_data;
         sum_buf_r[write_idx_s[idx_bw-1:0]] <= row_sum_s;
      end
   end

   // State, pointers, sticky overflow and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r     <= ST_IDLE;
         wr_ptr_r    <= {ptr_bw{1'b0}};
         rd_ptr_r    <= {ptr_bw{1'b0}};
         out_valid_r <= 1'b0;
         out_data_r  <= {(col*psum_bw){1'b0}};
         out_row_r   <= {addr_bw{1'b0}};
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
         overflow_r  <= 1'b0;
      end else begin
         state_r     <= state_nxt_s;
         busy_r      <= (state_nxt_s == ST_ACC) || (state_nxt_s == ST_DIV);
         done_r      <= (state_nxt_s == ST_DONE);
         out_valid_r <= issue_s;
         if (issue_s) begin
            out_data_r <= quot_s;
            out_row_r  <= rd_ptr_r[addr_bw-1:0];
         end
         if (restart_s)    rd_ptr_r <= {ptr_bw{1'b0}};
         else if (issue_s) rd_ptr_r <= rd_ptr_r + ptr_bw'(1);
         if (wr_en_s && !full_s) wr_ptr_r <= write_idx_s + ptr_bw'(1);
         else if (restart_s)     wr_ptr_r <= {ptr_bw{1'b0}};
         if (restart_s)                overflow_r <= 1'b0;
         else if (wr_en_s && full_s)   overflow_r <= 1'b1;
      end
   end

   assign out_valid = out_valid_r;
   assign out_data  = out_data_r;
   assign out_row   = out_row_r;
   assign busy      = busy_r;
   assign done      = done_r;
   assign overflow  = overflow_r;

endmodule
